diag_array_row_streamer: RTL and testbench

- Downstream consumer of the diagonal-array generator.
- Captures one ROWS x COLS array of BIT_WIDTH elements through a valid/ready handshake, then streams it out one row per accepted beat with row index and last flag.
- Converts the wide parallel array into a narrow row stream for row-serial datapaths such as MAC rows and writeback.

---
 rtl/diag_array_row_streamer.sv | 109 ++++++++++
 tb/tb_diag_array_row_streamer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/diag_array_row_streamer.sv
// diag_array_row_streamer
//   Captures one ROWS x COLS array of BIT_WIDTH elements over a valid/ready
//   handshake. It then streams the array out one row per accepted beat, with
//   the row index and a last flag.
//   Ports:
//     clk, rst_n              rising-edge clock, async active-low reset
//     in[ROWS][COLS]          array to capture (in[i][j] = row i, col j)
//     in_valid / in_ready     array handshake (ready only while idle)
//     out_row[COLS]           current row, element 0 first
//     out_row_idx             index of the row on out_row
//     out_valid / out_ready   row handshake
//     out_last                high with row ROWS-1
//     busy                    an array is held and not yet fully streamed
//   Every output is driven from a flop or decoded from the state flop, so
//   there is no combinational path from in/in_valid to any output.
module diag_array_row_streamer #(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int IDX_W     = $clog2(ROWS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIT_WIDTH-1:0] in [ROWS-1:0][COLS-1:0],
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BIT_WIDTH-1:0] out_row [COLS-1:0],
  output logic [IDX_W-1:0]     out_row_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy
);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d, cnt_nxt;
  logic [BIT_WIDTH-1:0] buf_q [ROWS-1:0][COLS-1:0];
  logic [BIT_WIDTH-1:0] buf_d [ROWS-1:0][COLS-1:0];
  logic [BIT_WIDTH-1:0] row_q [COLS-1:0];
  logic [BIT_WIDTH-1:0] row_d [COLS-1:0];
  logic                 last_q, last_d;

  assign cnt_nxt = cnt_q + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    row_d   = row_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_d   = in;
          row_d   = in[0];   // row 0 is presented the cycle after capture
          cnt_d   = '0;
          last_d  = 1'b0;    // ROWS >= 2, so row 0 is never the last row
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (cnt_q == LAST_IDX) begin
            // Return to the reset-like idle output image.
            state_d = IDLE;
            cnt_d   = '0;
            last_d  = 1'b0;
            for (int j = 0; j < COLS; j++) row_d[j] = '0;
          end else begin
            // Preload the next row so the output stays a pure flop.
            cnt_d  = cnt_nxt;
            row_d  = buf_q[cnt_nxt];
            last_d = (cnt_nxt == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) buf_q[i][j] <= '0;
      for (int j = 0; j < COLS; j++) row_q[j] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      buf_q   <= buf_d;
      row_q   <= row_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == STREAM);
  assign busy        = (state_q == STREAM);
  assign out_row     = row_q;
  assign out_row_idx = cnt_q;
  assign out_last    = last_q;

endmodule

// File: tb/tb_diag_array_row_streamer.sv
// Bench for diag_array_row_streamer: a 4x4 instance for directed diagonal,
// backpressure, busy-ignore and mid-stream-reset scenarios, and an 8x8
// instance for randomized arrays and random backpressure. The 8x8 instance is
// checked against a row scoreboard.
module tb_diag_array_row_streamer;

  typedef logic [3:0] arr_a_t [3:0][3:0];
  typedef logic [3:0] arr_b_t [7:0][7:0];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4x4 instance
  arr_a_t     a_in;
  logic       a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
  logic       a_out_last, a_busy;
  logic [3:0] a_out_row [3:0];
  logic [1:0] a_out_idx;

  // 8x8 instance
  arr_b_t     b_in;
  logic       b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
  logic       b_out_last, b_busy;
  logic [3:0] b_out_row [7:0];
  logic [2:0] b_out_idx;

  diag_array_row_streamer #(.BIT_WIDTH(4), .ROWS(4), .COLS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in(a_in), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_row(a_out_row), .out_row_idx(a_out_idx),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_last(a_out_last),
    .busy(a_busy));

  diag_array_row_streamer #(.BIT_WIDTH(4), .ROWS(8), .COLS(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in(b_in), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_row(b_out_row), .out_row_idx(b_out_idx),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_last(b_out_last),
    .busy(b_busy));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic arr_a_t diag_a(input logic [3:0] v);
    arr_a_t t;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) t[i][j] = (i == j) ? v : 4'h0;
    return t;
  endfunction

  function automatic logic [63:0] obs_row_a();
    logic [63:0] v = '0;
    for (int j = 0; j < 4; j++) v[j*4 +: 4] = a_out_row[j];
    return v;
  endfunction

  function automatic logic [63:0] obs_row_b();
    logic [63:0] v = '0;
    for (int j = 0; j < 8; j++) v[j*4 +: 4] = b_out_row[j];
    return v;
  endfunction

  function automatic logic [63:0] exp_row_a(input arr_a_t arr, input int r);
    logic [63:0] v = '0;
    for (int j = 0; j < 4; j++) v[j*4 +: 4] = arr[r][j];
    return v;
  endfunction

  // Capture arr on dut_a, then walk the stream with ready pattern pat
  // (bit k = ready on stream cycle k, high beyond plen). When junk is set,
  // a different array is offered with in_valid high throughout the stream.
  task automatic stream_a(input arr_a_t arr, input logic [15:0] pat,
                          input int plen, input bit junk);
    int   r;
    int   cyc;
    logic rdy;
    r = 0;
    cyc = 0;
    a_in = arr;
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    if (junk) a_in = diag_a(4'h5);
    else a_in_valid = 1'b0;
    while (r < 4 && cyc < 64) begin
      rdy = (cyc < plen) ? pat[cyc] : 1'b1;
      a_out_ready = rdy;
      chk("a_out_valid", 64'(a_out_valid), 64'd1);
      chk("a_in_ready_stream", 64'(a_in_ready), 64'd0);
      chk("a_busy_stream", 64'(a_busy), 64'd1);
      chk("a_idx", 64'(a_out_idx), 64'(r));
      chk("a_last", 64'(a_out_last), 64'(r == 3));
      chk("a_row", obs_row_a(), exp_row_a(arr, r));
      @(posedge clk); #1;
      if (rdy) r++;
      cyc++;
    end
    chk("a_handshakes", 64'(r), 64'd4);
    a_out_ready = 1'b0;
    chk("a_valid_after", 64'(a_out_valid), 64'd0);
    chk("a_in_ready_after", 64'(a_in_ready), 64'd1);
    chk("a_busy_after", 64'(a_busy), 64'd0);
  endtask

  // Random array on dut_b with random backpressure; the expected rows are
  // queued at capture and popped on every observed handshake.
  task automatic stream_b();
    arr_b_t      arr;
    logic [63:0] sb[$];
    logic [63:0] row;
    int          popped;
    int          lasts;
    int          cyc;
    logic        rdy;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) arr[i][j] = 4'($urandom);
    sb.delete();
    for (int i = 0; i < 8; i++) begin
      row = '0;
      for (int j = 0; j < 8; j++) row[j*4 +: 4] = arr[i][j];
      sb.push_back(row);
    end
    popped = 0;
    lasts = 0;
    cyc = 0;
    b_in = arr;
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) b_in[i][j] = 4'($urandom);
    while (sb.size() > 0 && cyc < 300) begin
      rdy = 1'($urandom_range(0, 1));
      b_out_ready = rdy;
      if (!b_out_valid) begin
        chk("b_valid_dropped", 64'(b_out_valid), 64'd1);
        break;
      end
      if (rdy) begin
        chk("b_row", obs_row_b(), sb.pop_front());
        chk("b_idx", 64'(b_out_idx), 64'(popped));
        if (b_out_last) lasts++;
        popped++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    b_out_ready = 1'b0;
    chk("b_rows_emitted", 64'(popped), 64'd8);
    chk("b_last_count", 64'(lasts), 64'd1);
    chk("b_idle_after", 64'(b_in_ready), 64'd1);
  endtask

  initial begin
    a_in = diag_a(4'h0);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) b_in[i][j] = 4'h0;

    // Reset then idle
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("rst_a_in_ready", 64'(a_in_ready), 64'd1);
      chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
      chk("rst_a_busy", 64'(a_busy), 64'd0);
      chk("rst_a_last", 64'(a_out_last), 64'd0);
      chk("rst_a_idx", 64'(a_out_idx), 64'd0);
      chk("rst_a_row", obs_row_a(), 64'd0);
      chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
      chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
      chk("rst_b_row", obs_row_b(), 64'd0);
    end

    // Diagonal stream, no backpressure
    stream_a(diag_a(4'hA), 16'h0, 0, 1'b0);

    // Backpressure 1,0,0,1,0,1,1
    stream_a(diag_a(4'hA), 16'b1101001, 7, 1'b0);

    // in_valid with a 5-array held during STREAM is ignored, then captured
    stream_a(diag_a(4'hA), 16'h0, 0, 1'b1);
    stream_a(diag_a(4'h5), 16'h0, 0, 1'b0);

    // Mid-stream asynchronous reset after the row-1 handshake
    a_in = diag_a(4'hC);
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    chk("mid_idx_before", 64'(a_out_idx), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_valid", 64'(a_out_valid), 64'd0);
    chk("mid_in_ready", 64'(a_in_ready), 64'd1);
    chk("mid_busy", 64'(a_busy), 64'd0);
    chk("mid_idx", 64'(a_out_idx), 64'd0);
    chk("mid_row", obs_row_a(), 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_still_idle", 64'(a_out_valid), 64'd0);
    stream_a(diag_a(4'h3), 16'h0, 0, 1'b0);

    // Random non-diagonal arrays on the 4x4 instance with random backpressure
    for (int n = 0; n < 3; n++) begin
      arr_a_t t;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) t[i][j] = 4'($urandom);
      stream_a(t, 16'($urandom), 16, 1'b0);
    end

    // Data integrity on the 8x8 instance
    for (int n = 0; n < 6; n++) stream_b();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
